mult8_seq_ctrl: RTL

//   Sequencer computing an unsigned 2W x 2W product (8x8 at default) on one shared W x W array

---
 rtl/mult8_seq_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/mult8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// mult8_seq_ctrl - 2W x 2W unsigned multiply sequenced over one W x W multiplier
// Revision: 1.0
// ============================================================================
module mult8_seq_ctrl #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [4*W-1:0] prod,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_prod
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PP0  = 3'd1;
  localparam logic [2:0] S_PP1  = 3'd2;
  localparam logic [2:0] S_PP2  = 3'd3;
  localparam logic [2:0] S_PP3  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]     state;
  logic [2:0]     state_nx;
  logic [2*W-1:0] a_r;
  logic [2*W-1:0] b_r;
  logic [4*W-1:0] acc;
  logic [4*W-1:0] pp_ext;
  logic [4*W-1:0] pp_shifted;
  logic           accept;

  assign busy   = (state == S_PP0) || (state == S_PP1) ||
                  (state == S_PP2) || (state == S_PP3);
  assign done   = (state == S_DONE);
  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign pp_ext = {{(2*W){1'b0}}, mul_prod};

  // Operand halves steered to the shared multiplier, with the matching weight
  always_comb begin
    mul_a      = '0;
    mul_b      = '0;
    pp_shifted = '0;
    case (state)
      S_PP0: begin
        mul_a      = a_r[W-1:0];
        mul_b      = b_r[W-1:0];
        pp_shifted = pp_ext;
      end
      S_PP1: begin
        mul_a      = a_r[2*W-1:W];
        mul_b      = b_r[W-1:0];
        pp_shifted = pp_ext << W;
      end
      S_PP2: begin
        mul_a      = a_r[W-1:0];
        mul_b      = b_r[2*W-1:W];
        pp_shifted = pp_ext << W;
      end
      S_PP3: begin
        mul_a      = a_r[2*W-1:W];
        mul_b      = b_r[2*W-1:W];
        pp_shifted = pp_ext << (2*W);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = start ? S_PP0 : S_IDLE;
      S_DONE:  state_nx = start ? S_PP0 : S_IDLE;
      S_PP0:   state_nx = S_PP1;
      S_PP1:   state_nx = S_PP2;
      S_PP2:   state_nx = S_PP3;
      S_PP3:   state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      acc   <= '0;
      prod  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_r <= a;
        b_r <= b;
        acc <= '0;
      end else if (busy) begin
        acc <= acc + pp_shifted;
      end
      // The final partial product bypasses acc so prod is ready in DONE
      if (state == S_PP3) begin
        prod <= acc + pp_shifted;
      end
    end
  end

endmodule
`default_nettype wire
